// File: rtl/clk_in_monitor.sv
// Per-channel toggle-clock monitor: counts synchronised rising edges per window, range-checks, reports OK/LOST.
// Edge-to-count latency SYNC_STG+1 cycles; CNT_VLD/CLK_OK/CLK_LOST update the cycle after the last window cycle; no backpressure.
module clk_in_monitor #(
  parameter int CH_NUM   = 4,
  parameter int WIN_CYC  = 65536,
  parameter int CNT_W    = 16,
  parameter int GOOD_WIN = 4,
  parameter int SYNC_STG = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    MON_EN,
  input  logic [CH_NUM-1:0]       TGL_IN,
  input  logic [CH_NUM*CNT_W-1:0] CNT_MIN,
  input  logic [CH_NUM*CNT_W-1:0] CNT_MAX,
  input  logic [CH_NUM-1:0]       LOST_CLR,
  output logic [CH_NUM*CNT_W-1:0] CNT_OUT,
  output logic                    CNT_VLD,
  output logic [CH_NUM-1:0]       CLK_OK,
  output logic [CH_NUM-1:0]       CLK_LOST
);

  localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int STK_W = $clog2(GOOD_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(GOOD_WIN);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic [CH_NUM-1:0][SYNC_STG-1:0] sync_q;
  logic [CH_NUM-1:0]               sync_out;
  logic [CH_NUM-1:0]               hist_q;
  logic [CH_NUM-1:0]               rise;
  logic [WIN_W-1:0]                win_cnt;
  logic                            win_last;
  logic [CH_NUM-1:0][CNT_W-1:0]    edge_cnt;
  logic [CH_NUM-1:0][CNT_W-1:0]    edge_nxt;
  logic [CH_NUM-1:0][CNT_W-1:0]    lim_min;
  logic [CH_NUM-1:0][CNT_W-1:0]    lim_max;
  logic [CH_NUM-1:0][STK_W-1:0]    streak;
  logic [CH_NUM-1:0][STK_W-1:0]    stk_nxt;
  logic [CH_NUM-1:0]               win_good;
  logic [CH_NUM-1:0]               ok_nxt;
  logic [CH_NUM-1:0]               lost_set;

  assign lim_min  = CNT_MIN;
  assign lim_max  = CNT_MAX;
  assign win_last = (win_cnt == WIN_LAST);

  always_comb begin
    sync_out = '0;
    rise     = '0;
    edge_nxt = edge_cnt;
    win_good = '0;
    stk_nxt  = '0;
    ok_nxt   = '0;
    lost_set = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      sync_out[i] = sync_q[i][SYNC_STG-1];
      rise[i]     = sync_out[i] & ~hist_q[i];
      if (rise[i] && (edge_cnt[i] != CNT_SAT))
        edge_nxt[i] = edge_cnt[i] + 1'b1;
      // the window verdict includes an edge landing on the last window cycle
      win_good[i] = (edge_nxt[i] >= lim_min[i]) && (edge_nxt[i] <= lim_max[i]);
      if (win_good[i])
        stk_nxt[i] = (streak[i] == STK_MAX) ? STK_MAX : streak[i] + 1'b1;
      ok_nxt[i]   = (stk_nxt[i] == STK_MAX);
      lost_set[i] = MON_EN & win_last & CLK_OK[i] & ~win_good[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q   <= '0;
      hist_q   <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      streak   <= '0;
      CNT_OUT  <= '0;
      CNT_VLD  <= 1'b0;
      CLK_OK   <= '0;
      CLK_LOST <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++)
        sync_q[i] <= {sync_q[i][SYNC_STG-2:0], TGL_IN[i]};
      hist_q   <= sync_out;
      CNT_VLD  <= MON_EN & win_last;
      // a loss in the same cycle as a clear must not be dropped
      CLK_LOST <= lost_set | (CLK_LOST & ~LOST_CLR);
      if (!MON_EN) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        streak   <= '0;
        CLK_OK   <= '0;
      end else if (win_last) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        streak   <= stk_nxt;
        CLK_OK   <= ok_nxt;
        CNT_OUT  <= edge_nxt;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clk_in_monitor.sv
// Directed bench for clk_in_monitor: window-level reference model checked every cycle plus literal spot checks.
module tb_clk_in_monitor;

  localparam int CH_NUM   = 4;
  localparam int WIN_CYC  = 1024;
  localparam int CNT_W    = 8;
  localparam int GOOD_WIN = 4;
  localparam int SYNC_STG = 2;
  localparam int CNT_CAP  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    mon_en;
  logic [CH_NUM-1:0]       tgl_in;
  logic [CH_NUM*CNT_W-1:0] cnt_min;
  logic [CH_NUM*CNT_W-1:0] cnt_max;
  logic [CH_NUM-1:0]       lost_clr;
  logic [CH_NUM*CNT_W-1:0] cnt_out;
  logic                    cnt_vld;
  logic [CH_NUM-1:0]       clk_ok;
  logic [CH_NUM-1:0]       clk_lost;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] cyc         = '0;
  logic [CH_NUM-1:0] tgl_run = '0;

  clk_in_monitor #(
    .CH_NUM(CH_NUM), .WIN_CYC(WIN_CYC), .CNT_W(CNT_W),
    .GOOD_WIN(GOOD_WIN), .SYNC_STG(SYNC_STG)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .MON_EN(mon_en), .TGL_IN(tgl_in),
    .CNT_MIN(cnt_min), .CNT_MAX(cnt_max), .LOST_CLR(lost_clr),
    .CNT_OUT(cnt_out), .CNT_VLD(cnt_vld), .CLK_OK(clk_ok), .CLK_LOST(clk_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: edges seen SYNC_STG edges after sampling, summed per window of enabled cycles
  bit                      m_dl [CH_NUM][SYNC_STG+1];
  int                      m_sum [CH_NUM];
  int                      m_streak [CH_NUM];
  bit                      m_rise [CH_NUM];
  logic [CH_NUM-1:0]       m_ok, m_lost, m_set;
  logic [CH_NUM*CNT_W-1:0] m_cnt_out;
  bit                      m_vld;
  int                      m_run;
  bit                      model_ready = 1'b0;
  int                      c, lo, hi;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_ready = 1'b1;
      m_vld = 1'b0; m_run = 0; m_cnt_out = '0; m_ok = '0; m_lost = '0;
      for (int i = 0; i < CH_NUM; i++) begin
        m_sum[i] = 0; m_streak[i] = 0;
        for (int k = 0; k <= SYNC_STG; k++) m_dl[i][k] = 1'b0;
      end
    end else begin
      m_vld = 1'b0;
      m_set = '0;
      for (int i = 0; i < CH_NUM; i++) begin
        m_rise[i] = m_dl[i][SYNC_STG-1] && !m_dl[i][SYNC_STG];
        for (int k = SYNC_STG; k > 0; k--) m_dl[i][k] = m_dl[i][k-1];
        m_dl[i][0] = tgl_in[i];
      end
      if (mon_en) begin
        m_run++;
        for (int i = 0; i < CH_NUM; i++) if (m_rise[i]) m_sum[i]++;
        if (m_run % WIN_CYC == 0) begin
          m_vld = 1'b1;
          for (int i = 0; i < CH_NUM; i++) begin
            c  = (m_sum[i] > CNT_CAP) ? CNT_CAP : m_sum[i];
            lo = int'(cnt_min[i*CNT_W +: CNT_W]);
            hi = int'(cnt_max[i*CNT_W +: CNT_W]);
            m_cnt_out[i*CNT_W +: CNT_W] = c[CNT_W-1:0];
            if (c >= lo && c <= hi) begin
              m_streak[i] = (m_streak[i] >= GOOD_WIN) ? GOOD_WIN : m_streak[i] + 1;
            end else begin
              m_set[i] = m_ok[i];
              m_streak[i] = 0;
            end
            m_ok[i]  = (m_streak[i] >= GOOD_WIN);
            m_sum[i] = 0;
          end
        end
      end else begin
        m_run = 0; m_ok = '0;
        for (int i = 0; i < CH_NUM; i++) begin m_sum[i] = 0; m_streak[i] = 0; end
      end
      for (int i = 0; i < CH_NUM; i++)
        m_lost[i] = m_set[i] ? 1'b1 : (lost_clr[i] ? 1'b0 : m_lost[i]);
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("cnt_vld", 32'(cnt_vld), 32'(m_vld));
      chk("clk_ok", 32'(clk_ok), 32'(m_ok));
      chk("clk_lost", 32'(clk_lost), 32'(m_lost));
      chk("cnt_out", 32'(cnt_out), 32'(m_cnt_out));
    end
  end

  // ch0 rises every 8 cycles, ch1/ch2 every 2, ch3 every 16
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      tgl_in[0] = tgl_run[0] & cyc[2];
      tgl_in[1] = tgl_run[1] & cyc[0];
      tgl_in[2] = tgl_run[2] & cyc[0];
      tgl_in[3] = tgl_run[3] & cyc[3];
    end
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!cnt_vld && n < WIN_CYC + 16);
    if (!cnt_vld) begin
      vectors++;
      miscompares++;
      $display("FAIL vld_timeout: no CNT_VLD after %0d cycles, required within %0d", n, WIN_CYC);
    end
  endtask

  int n;
  int seen;

  initial begin
    rst_n    = 1'b0;
    mon_en   = 1'b0;
    lost_clr = '0;
    tgl_in   = '0;
    cnt_min  = {8'd70, 8'd0,   8'd0,   8'd120};
    cnt_max  = {8'd60, 8'd254, 8'd255, 8'd136};
    tick(5);
    chk("rst_vld", 32'(cnt_vld), 0);
    chk("rst_ok", 32'(clk_ok), 0);
    chk("rst_lost", 32'(clk_lost), 0);
    chk("rst_cnt", 32'(cnt_out), 0);

    rst_n = 1'b1; mon_en = 1'b1; tgl_run = 4'hF;
    wait_vld(n);
    chk("first_vld_lat", n, WIN_CYC);
    chk("ok0_w1", 32'(clk_ok[0]), 0);
    wait_vld(n);
    chk("vld_period", n, WIN_CYC);
    chk("ok0_w2", 32'(clk_ok[0]), 0);
    wait_vld(n);
    chk("ok0_w3", 32'(clk_ok[0]), 0);
    chk("cnt0_w3", 32'(cnt_out[7:0]), 128);
    wait_vld(n);
    chk("ok0_w4", 32'(clk_ok[0]), 1);
    chk("cnt0_w4", 32'(cnt_out[7:0]), 128);
    chk("cnt1_sat", 32'(cnt_out[15:8]), 255);
    chk("ok1_max255", 32'(clk_ok[1]), 1);
    chk("cnt2_sat", 32'(cnt_out[23:16]), 255);
    chk("ok2_max254", 32'(clk_ok[2]), 0);
    chk("cnt3", 32'(cnt_out[31:24]), 64);
    chk("ok3_min_gt_max", 32'(clk_ok[3]), 0);

    // loss of ch0, then a one-cycle clear
    tgl_run[0] = 1'b0;
    wait_vld(n);
    chk("lost_cnt_le1", 32'(cnt_out[7:0] <= 8'd1), 1);
    chk("lost_ok0", 32'(clk_ok[0]), 0);
    chk("lost_set0", 32'(clk_lost[0]), 1);
    chk("lost_ch1_quiet", 32'(clk_lost[1]), 0);
    lost_clr = 4'b0001;
    tick(1);
    lost_clr = '0;
    chk("lost_clr0", 32'(clk_lost[0]), 0);

    // clear held across a failing window: set wins, clear takes effect next cycle
    tgl_run[0] = 1'b1;
    repeat (4) wait_vld(n);
    chk("reok0", 32'(clk_ok[0]), 1);
    lost_clr = 4'b0001;
    tgl_run[0] = 1'b0;
    wait_vld(n);
    chk("setwins_lost0", 32'(clk_lost[0]), 1);
    tick(1);
    chk("held_clr_lost0", 32'(clk_lost[0]), 0);
    lost_clr = '0;

    // disable mid-window after OK
    tgl_run[0] = 1'b1;
    repeat (4) wait_vld(n);
    chk("reok0_b", 32'(clk_ok[0]), 1);
    tick(300);
    mon_en = 1'b0;
    tick(1);
    chk("dis_ok", 32'(clk_ok), 0);
    chk("dis_lost", 32'(clk_lost), 0);
    seen = 0;
    for (int k = 0; k < 1500; k++) begin
      tick(1);
      if (cnt_vld) seen++;
    end
    chk("dis_no_vld", seen, 0);
    chk("dis_cnt_hold", 32'(cnt_out[7:0]), 128);
    chk("dis_lost_hold", 32'(clk_lost), 0);
    mon_en = 1'b1;
    wait_vld(n);
    chk("reen_vld_lat", n, WIN_CYC);

    // one-cycle reset mid-window
    tick(500);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mrst_vld", 32'(cnt_vld), 0);
    chk("mrst_ok", 32'(clk_ok), 0);
    chk("mrst_lost", 32'(clk_lost), 0);
    chk("mrst_cnt", 32'(cnt_out), 0);
    wait_vld(n);
    chk("mrst_vld_lat", n, WIN_CYC);
    chk("mrst_ok0", 32'(clk_ok[0]), 0);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
